// File: rtl/cpu_defs.sv
// Shared CPU definitions: widths, ALU op bit indices,
// multiply/divide op codes and the ID->EX pipeline bundle.
package cpu_defs;

  localparam int XLEN      = 32;
  localparam int GPR_W     = 5;
  localparam int ALUOP_W   = 12;
  localparam int MD_W      = 4;
  localparam int DIV_ITERS = 32;

  localparam int ALUOP_ADD  = 11;
  localparam int ALUOP_SUB  = 10;
  localparam int ALUOP_SLT  = 9;
  localparam int ALUOP_SLTU = 8;
  localparam int ALUOP_AND  = 7;
  localparam int ALUOP_NOR  = 6;
  localparam int ALUOP_OR   = 5;
  localparam int ALUOP_XOR  = 4;
  localparam int ALUOP_SLL  = 3;
  localparam int ALUOP_SRL  = 2;
  localparam int ALUOP_SRA  = 1;
  localparam int ALUOP_LUI  = 0;

  typedef enum logic [MD_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [ALUOP_W-1:0] aluop;
    logic [XLEN-1:0]    src1;
    logic [XLEN-1:0]    src2;
    logic [XLEN-1:0]    rt_val;
    logic [GPR_W-1:0]   dest;
    md_op_e             md_op;
    logic               mem_re;
    logic               mem_we;
  } id_ex_t;

endpackage

// File: rtl/alu.sv
// Integer ALU driven by a one-hot operation select.
// Shifts use src1[4:0] as amount and shift src2.
module alu
  import cpu_defs::*;
(
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [XLEN-1:0]    src1_i,
  input  logic [XLEN-1:0]    src2_i,
  output logic [XLEN-1:0]    result_o
);

  logic [4:0] sa;

  assign sa = src1_i[4:0];

  // One-hot select; an all-zero op yields zero.
  always_comb begin
    result_o = '0;
    unique case (1'b1)
      aluop_i[ALUOP_ADD]:
        result_o = src1_i + src2_i;
      aluop_i[ALUOP_SUB]:
        result_o = src1_i - src2_i;
      aluop_i[ALUOP_SLT]:
        result_o = {31'd0,
          $signed(src1_i) < $signed(src2_i)};
      aluop_i[ALUOP_SLTU]:
        result_o = {31'd0, src1_i < src2_i};
      aluop_i[ALUOP_AND]:
        result_o = src1_i & src2_i;
      aluop_i[ALUOP_NOR]:
        result_o = ~(src1_i | src2_i);
      aluop_i[ALUOP_OR]:
        result_o = src1_i | src2_i;
      aluop_i[ALUOP_XOR]:
        result_o = src1_i ^ src2_i;
      aluop_i[ALUOP_SLL]:
        result_o = src2_i << sa;
      aluop_i[ALUOP_SRL]:
        result_o = src2_i >> sa;
      aluop_i[ALUOP_SRA]:
        result_o = $signed(src2_i) >>> sa;
      aluop_i[ALUOP_LUI]:
        result_o = {src2_i[15:0], 16'd0};
      default:
        result_o = '0;
    endcase
  end

endmodule

// File: rtl/div_iter.sv
// Restoring radix-2 divider, one quotient bit per cycle.
// Signed mode divides magnitudes and fixes signs on output.
module div_iter
  import cpu_defs::*;
(
  input  logic            clk,
  input  logic            resetn,
  input  logic            start_i,
  input  logic            sgn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            abort_i,
  input  logic            ack_i,
  output logic            done_o,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o
);

  div_state_e      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shf, diff;

  assign a_mag = (sgn_i & a_i[31]) ? -a_i : a_i;
  assign b_mag = (sgn_i & b_i[31]) ? -b_i : b_i;
  assign shf   = {rem_q, quo_q[31]};
  assign diff  = shf - {1'b0, dvs_q};

  assign done_o = (state_q == DIV_DONE);
  assign quo_o  = qneg_q ? -quo_q : quo_q;
  assign rem_o  = rneg_q ? -rem_q : rem_q;

  // Next-state: load on start, iterate, hold result until ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          quo_d   = a_mag;
          rem_d   = '0;
          dvs_d   = b_mag;
          qneg_d  = sgn_i & (a_i[31] ^ b_i[31]);
          rneg_d  = sgn_i & a_i[31];
        end
      end
      DIV_BUSY: begin
        rem_d = diff[XLEN] ? shf[XLEN-1:0]
                           : diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (ack_i) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
    if (abort_i) begin
      state_d = DIV_IDLE;
    end
  end

  // Divider state and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: ID->EX register, ALU, HI/LO with
// multiply and iterative divide, handshake to MEM.
module exe_stage
  import cpu_defs::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               ds_to_es_valid,
  output logic               es_allowin,
  input  logic [XLEN-1:0]    ds_pc,
  input  logic [ALUOP_W-1:0] ds_aluop,
  input  logic [XLEN-1:0]    ds_src1,
  input  logic [XLEN-1:0]    ds_src2,
  input  logic [XLEN-1:0]    ds_rt_val,
  input  logic [GPR_W-1:0]   ds_dest,
  input  logic [MD_W-1:0]    ds_md_op,
  input  logic               ds_mem_re,
  input  logic               ds_mem_we,
  input  logic               ms_allowin,
  output logic               es_to_ms_valid,
  output logic [XLEN-1:0]    es_pc,
  output logic [XLEN-1:0]    es_result,
  output logic [XLEN-1:0]    es_rt_val,
  output logic [GPR_W-1:0]   es_dest,
  output logic               es_mem_re,
  output logic               es_mem_we,
  output logic               es_fwd_ready
);

  id_ex_t          ex_q, ex_d;
  logic            es_valid_q, es_valid_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] quo, rem;
  logic [63:0]     pa, pb, prod;
  logic            msgn, is_div, div_done;
  logic            es_ready_go, handoff;

  assign is_div = (ex_q.md_op == MD_DIV) |
                  (ex_q.md_op == MD_DIVU);
  assign es_ready_go = ~is_div | div_done;
  assign es_allowin  = ~es_valid_q |
                       (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid_q & es_ready_go;
  assign handoff = es_to_ms_valid & ms_allowin;

  assign msgn = (ex_q.md_op == MD_MULT);
  assign pa   = {{32{msgn & ex_q.src1[31]}}, ex_q.src1};
  assign pb   = {{32{msgn & ex_q.src2[31]}}, ex_q.src2};
  assign prod = pa * pb;

  assign es_pc     = ex_q.pc;
  assign es_rt_val = ex_q.rt_val;
  assign es_dest   = ex_q.dest;
  assign es_mem_re = ex_q.mem_re;
  assign es_mem_we = ex_q.mem_we;
  assign es_fwd_ready = es_valid_q & es_ready_go &
                        ~ex_q.mem_re &
                        (ex_q.dest != '0);

  alu u_alu (
    .aluop_i  (ex_q.aluop),
    .src1_i   (ex_q.src1),
    .src2_i   (ex_q.src2),
    .result_o (alu_res)
  );

  div_iter u_div (
    .clk     (clk),
    .resetn  (resetn),
    .start_i (es_valid_q & is_div),
    .sgn_i   (ex_q.md_op == MD_DIV),
    .a_i     (ex_q.src1),
    .b_i     (ex_q.src2),
    .abort_i (flush),
    .ack_i   (handoff),
    .done_o  (div_done),
    .quo_o   (quo),
    .rem_o   (rem)
  );

  // Result mux: HI/LO moves bypass the ALU.
  always_comb begin
    es_result = alu_res;
    if (ex_q.md_op == MD_MFHI) begin
      es_result = hi_q;
    end else if (ex_q.md_op == MD_MFLO) begin
      es_result = lo_q;
    end
  end

  // Pack the decode bundle for the pipeline register.
  always_comb begin
    ex_d        = ex_q;
    ex_d.pc     = ds_pc;
    ex_d.aluop  = ds_aluop;
    ex_d.src1   = ds_src1;
    ex_d.src2   = ds_src2;
    ex_d.rt_val = ds_rt_val;
    ex_d.dest   = ds_dest;
    ex_d.md_op  = md_op_e'(ds_md_op);
    ex_d.mem_re = ds_mem_re;
    ex_d.mem_we = ds_mem_we;
  end

  // Valid bit: flush beats a simultaneous accept.
  always_comb begin
    es_valid_d = es_valid_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
  end

  // HI/LO update only when the op leaves EX unflushed.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (handoff & ~flush) begin
      unique case (ex_q.md_op)
        MD_MULT, MD_MULTU: begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
        MD_DIV, MD_DIVU: begin
          hi_d = rem;
          lo_d = quo;
        end
        MD_MTHI: hi_d = ex_q.src1;
        MD_MTLO: lo_d = ex_q.src1;
        default: ;
      endcase
    end
  end

  // Pipeline register, valid bit and HI/LO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_q       <= '0;
      es_valid_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      es_valid_q <= es_valid_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      if (ds_to_es_valid & es_allowin) begin
        ex_q <= ex_d;
      end
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, stall,
// multiply, divide, flush and reset behaviour.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        ds_to_es_valid;
  logic        es_allowin;
  logic [31:0] ds_pc;
  logic [11:0] ds_aluop;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [31:0] ds_rt_val;
  logic [4:0]  ds_dest;
  logic [3:0]  ds_md_op;
  logic        ds_mem_re;
  logic        ds_mem_we;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [31:0] es_rt_val;
  logic [4:0]  es_dest;
  logic        es_mem_re;
  logic        es_mem_we;
  logic        es_fwd_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk            (clk),
    .resetn         (resetn),
    .flush          (flush),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_pc          (ds_pc),
    .ds_aluop       (ds_aluop),
    .ds_src1        (ds_src1),
    .ds_src2        (ds_src2),
    .ds_rt_val      (ds_rt_val),
    .ds_dest        (ds_dest),
    .ds_md_op       (ds_md_op),
    .ds_mem_re      (ds_mem_re),
    .ds_mem_we      (ds_mem_we),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_pc          (es_pc),
    .es_result      (es_result),
    .es_rt_val      (es_rt_val),
    .es_dest        (es_dest),
    .es_mem_re      (es_mem_re),
    .es_mem_we      (es_mem_we),
    .es_fwd_ready   (es_fwd_ready)
  );

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [11:0] op,
    input logic [3:0]  md,
    input logic [31:0] s1,
    input logic [31:0] s2,
    input logic [4:0]  dst,
    input logic [31:0] pc,
    input logic        re
  );
    ds_to_es_valid = 1'b1;
    ds_aluop  = op;
    ds_md_op  = md;
    ds_src1   = s1;
    ds_src2   = s2;
    ds_rt_val = s2 ^ 32'h5a5a5a5a;
    ds_dest   = dst;
    ds_pc     = pc;
    ds_mem_re = re;
    ds_mem_we = 1'b0;
  endtask

  task automatic read_hilo(
    output logic [31:0] hi,
    output logic [31:0] lo
  );
    drive(12'h0, 4'd5, 0, 0, 5'd2, 32'h900, 1'b0);
    step();
    hi = es_result;
    drive(12'h0, 4'd6, 0, 0, 5'd2, 32'h904, 1'b0);
    step();
    lo = es_result;
    ds_to_es_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    flush = 1'b0;
    ms_allowin = 1'b1;
    drive(OP_ADD, 4'd0, 1, 2, 5'd1, 32'h44, 1'b0);
    ds_to_es_valid = 1'b0;
    step();
    step();
    total++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
      bad++;
      $display("FAIL reset_hs got v=%b a=%b want v=0 a=1",
               es_to_ms_valid, es_allowin);
    end
    total++;
    if (es_result !== 32'h0 || es_pc !== 32'h0 ||
        es_fwd_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got r=%h pc=%h f=%b want 0",
               es_result, es_pc, es_fwd_ready);
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_add();
    drive(OP_ADD, 4'd0, 5, 7, 5'd3, 32'h100, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    total++;
    if (es_to_ms_valid !== 1'b1 || es_result !== 32'd12) begin
      bad++;
      $display("FAIL add got v=%b r=%h want v=1 r=0000000c",
               es_to_ms_valid, es_result);
    end
    total++;
    if (es_fwd_ready !== 1'b1 || es_pc !== 32'h100 ||
        es_dest !== 5'd3 ||
        es_rt_val !== (32'd7 ^ 32'h5a5a5a5a)) begin
      bad++;
      $display("FAIL add_meta got f=%b pc=%h d=%0d rt=%h",
               es_fwd_ready, es_pc, es_dest, es_rt_val);
    end
    step();
    total++;
    if (es_to_ms_valid !== 1'b0) begin
      bad++;
      $display("FAIL add_drain got %b want 0", es_to_ms_valid);
    end
  endtask

  task automatic test_hold();
    ms_allowin = 1'b0;
    drive(OP_SUB, 4'd0, 10, 3, 5'd4, 32'h200, 1'b0);
    step();
    drive(OP_ADD, 4'd0, 1, 1, 5'd6, 32'h300, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (es_allowin !== 1'b0 || es_to_ms_valid !== 1'b1 ||
          es_pc !== 32'h200 || es_result !== 32'd7 ||
          es_dest !== 5'd4) begin
        bad++;
        $display("FAIL hold%0d got a=%b v=%b pc=%h r=%h d=%0d",
                 i, es_allowin, es_to_ms_valid, es_pc,
                 es_result, es_dest);
      end
      step();
    end
    ms_allowin = 1'b1;
    #1;
    total++;
    if (es_allowin !== 1'b1) begin
      bad++;
      $display("FAIL hold_release got %b want 1", es_allowin);
    end
    step();
    ds_to_es_valid = 1'b0;
    total++;
    if (es_pc !== 32'h300 || es_result !== 32'd2) begin
      bad++;
      $display("FAIL hold_next got pc=%h r=%h want 300 2",
               es_pc, es_result);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [11:0] op [12];
    logic [31:0] a  [12];
    logic [31:0] b  [12];
    logic [31:0] ex [12];
    op[0]  = OP_SUB;  a[0]  = 0;            b[0]  = 1;
    ex[0]  = 32'hffffffff;
    op[1]  = OP_SLT;  a[1]  = 32'hffffffff; b[1]  = 1;
    ex[1]  = 32'd1;
    op[2]  = OP_SLTU; a[2]  = 32'hffffffff; b[2]  = 1;
    ex[2]  = 32'd0;
    op[3]  = OP_AND;  a[3]  = 32'hf0f0;     b[3]  = 32'hff00;
    ex[3]  = 32'hf000;
    op[4]  = OP_NOR;  a[4]  = 0;            b[4]  = 0;
    ex[4]  = 32'hffffffff;
    op[5]  = OP_OR;   a[5]  = 32'h0f;       b[5]  = 32'hf0;
    ex[5]  = 32'hff;
    op[6]  = OP_XOR;  a[6]  = 32'hff;       b[6]  = 32'h0f;
    ex[6]  = 32'hf0;
    op[7]  = OP_SLL;  a[7]  = 4;            b[7]  = 1;
    ex[7]  = 32'h10;
    op[8]  = OP_SRL;  a[8]  = 4;            b[8]  = 32'h80000000;
    ex[8]  = 32'h08000000;
    op[9]  = OP_SRA;  a[9]  = 4;            b[9]  = 32'h80000000;
    ex[9]  = 32'hf8000000;
    op[10] = OP_LUI;  a[10] = 0;            b[10] = 32'h1234;
    ex[10] = 32'h12340000;
    op[11] = OP_ADD;  a[11] = 32'h7fffffff; b[11] = 1;
    ex[11] = 32'h80000000;
    for (int i = 0; i < 12; i++) begin
      drive(op[i], 4'd0, a[i], b[i], 5'd1, 32'h400 + i, 1'b0);
      step();
      total++;
      if (es_to_ms_valid !== 1'b1 || es_result !== ex[i] ||
          es_pc !== 32'h400 + i) begin
        bad++;
        $display("FAIL alu%0d got v=%b r=%h want r=%h",
                 i, es_to_ms_valid, es_result, ex[i]);
      end
    end
    drive(OP_ADD, 4'd0, 32'h1000, 8, 5'd5, 32'h500, 1'b1);
    step();
    total++;
    if (es_fwd_ready !== 1'b0 || es_mem_re !== 1'b1 ||
        es_result !== 32'h1008) begin
      bad++;
      $display("FAIL load_fwd got f=%b re=%b r=%h",
               es_fwd_ready, es_mem_re, es_result);
    end
    drive(OP_ADD, 4'd0, 1, 2, 5'd0, 32'h504, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    total++;
    if (es_fwd_ready !== 1'b0 || es_result !== 32'd3) begin
      bad++;
      $display("FAIL dest0_fwd got f=%b r=%h",
               es_fwd_ready, es_result);
    end
    step();
  endtask

  task automatic test_div();
    logic [31:0] hi, lo;
    int early;
    early = 0;
    drive(12'h0, 4'd3, 32'hfffffff9, 2, 5'd0, 32'h600, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    for (int k = 0; k <= 32; k++) begin
      if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b0) begin
        early++;
      end
      step();
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL div_wait got %0d early cycles want 0",
               early);
    end
    total++;
    if (es_to_ms_valid !== 1'b1) begin
      bad++;
      $display("FAIL div_done got %b want 1 at E+33",
               es_to_ms_valid);
    end
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'hffffffff || lo !== 32'hfffffffd) begin
      bad++;
      $display("FAIL div_hilo got hi=%h lo=%h want ffffffff fffffffd",
               hi, lo);
    end
    step();
  endtask

  task automatic test_mult();
    logic [31:0] hi, lo;
    drive(12'h0, 4'd2, 32'hffffffff, 32'hffffffff,
          5'd0, 32'h700, 1'b0);
    step();
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'hfffffffe || lo !== 32'h1) begin
      bad++;
      $display("FAIL multu got hi=%h lo=%h want fffffffe 1",
               hi, lo);
    end
    drive(12'h0, 4'd1, 32'hffffffff, 32'hffffffff,
          5'd0, 32'h704, 1'b0);
    step();
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'h0 || lo !== 32'h1) begin
      bad++;
      $display("FAIL mult got hi=%h lo=%h want 0 1", hi, lo);
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] hi, lo;
    int n;
    drive(12'h0, 4'd7, 32'haaaa, 0, 5'd0, 32'h800, 1'b0);
    step();
    drive(12'h0, 4'd8, 32'h5555, 0, 5'd0, 32'h804, 1'b0);
    step();
    drive(12'h0, 4'd3, 1000, 3, 5'd0, 32'h808, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    repeat (11) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
      bad++;
      $display("FAIL flush got v=%b a=%b want 0 1",
               es_to_ms_valid, es_allowin);
    end
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'haaaa || lo !== 32'h5555) begin
      bad++;
      $display("FAIL flush_hilo got hi=%h lo=%h want aaaa 5555",
               hi, lo);
    end
    drive(12'h0, 4'd4, 100, 7, 5'd0, 32'h80c, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    n = 0;
    while (es_to_ms_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    total++;
    if (n != 33) begin
      bad++;
      $display("FAIL divu_latency got %0d want 33", n);
    end
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      bad++;
      $display("FAIL divu got hi=%h lo=%h want 2 e", hi, lo);
    end
    step();
  endtask

  task automatic test_divzero_reset();
    logic [31:0] hi, lo;
    drive(12'h0, 4'd4, 9, 0, 5'd0, 32'ha00, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    repeat (33) step();
    total++;
    if (es_to_ms_valid !== 1'b1) begin
      bad++;
      $display("FAIL div0_done got %b want 1", es_to_ms_valid);
    end
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'd9 || lo !== 32'hffffffff) begin
      bad++;
      $display("FAIL div0 got hi=%h lo=%h want 9 ffffffff",
               hi, lo);
    end
    step();
    drive(12'h0, 4'd3, 50, 5, 5'd0, 32'ha04, 1'b0);
    step();
    ds_to_es_valid = 1'b0;
    repeat (5) step();
    resetn = 1'b0;
    #1;
    total++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 ||
        es_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid got v=%b a=%b pc=%h",
               es_to_ms_valid, es_allowin, es_pc);
    end
    step();
    resetn = 1'b1;
    step();
    read_hilo(hi, lo);
    total++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      bad++;
      $display("FAIL rst_hilo got hi=%h lo=%h want 0 0", hi, lo);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_hold();
    test_back_to_back();
    test_div();
    test_mult();
    test_flush();
    test_divzero_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
